// File: rtl/ip_codma_bus_master_if.sv
// Bus-side signals of the channel DMA bus master.
// The master modport drives requests and write beats; the slave modport answers them.
interface ip_codma_bus_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int SIZE_W = 4
);
  logic              bus_read_o;
  logic              bus_write_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [SIZE_W-1:0] bus_size_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic              bus_write_valid_o;
  logic              bus_grant_i;
  logic              bus_rvalid_i;
  logic [DATA_W-1:0] bus_rdata_i;
  logic              bus_wready_i;

  modport master (
    output bus_read_o, bus_write_o, bus_addr_o, bus_size_o, bus_wdata_o, bus_write_valid_o,
    input  bus_grant_i, bus_rvalid_i, bus_rdata_i, bus_wready_i
  );

  modport slave (
    input  bus_read_o, bus_write_o, bus_addr_o, bus_size_o, bus_wdata_o, bus_write_valid_o,
    output bus_grant_i, bus_rvalid_i, bus_rdata_i, bus_wready_i
  );
endinterface

// File: rtl/ip_codma_bus_master.sv
// Round-robin multi-channel bus master: arbitrates channel requests, runs one
// read or write burst on the shared bus, and reports done/abort per channel.
//
// state | meaning
// IDLE  | arbitrate channel requests (blocked while stop_i is high)
// REQ   | bus strobe asserted, waiting for grant
// DATA  | moving beats; timeout restarts on every accepted beat
// DONE  | owner done pulse visible, return to IDLE
// ABORT | owner error pulse visible, return to IDLE
module ip_codma_bus_master #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int SIZE_W  = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          stop_i,
  input  logic [NUM_CH-1:0]             ch_req_i,
  input  logic [NUM_CH-1:0]             ch_wr_i,
  input  logic [NUM_CH-1:0][ADDR_W-1:0] ch_addr_i,
  input  logic [NUM_CH-1:0][SIZE_W-1:0] ch_size_i,
  input  logic [NUM_CH-1:0][DATA_W-1:0] ch_wdata_i,
  output logic [NUM_CH-1:0]             ch_ack_o,
  output logic [NUM_CH-1:0]             ch_wnext_o,
  output logic [NUM_CH-1:0]             ch_rvalid_o,
  output logic [DATA_W-1:0]             ch_rdata_o,
  output logic [NUM_CH-1:0]             ch_done_o,
  output logic [NUM_CH-1:0]             ch_err_o,
  ip_codma_bus_master_if.master         bus
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    DATA  = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  sel;
  logic [IDX_W-1:0]  ptr_next;
  logic              found;
  logic              own_wr;
  logic [SIZE_W-1:0] own_size;
  logic [SIZE_W-1:0] beat_cnt;
  logic [15:0]       tmo_cnt;
  logic [NUM_CH-1:0] own_1h;
  logic [NUM_CH-1:0] sel_1h;
  logic              beat_ok;
  logic              last_beat;
  int                idx;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(ptr) + i) % NUM_CH;
      if (!found && ch_req_i[idx]) begin
        found = 1'b1;
        sel   = IDX_W'(idx);
      end
    end
  end

  assign ptr_next  = (int'(sel) == NUM_CH - 1) ? '0 : sel + 1'b1;
  assign own_1h    = NUM_CH'(1) << owner;
  assign sel_1h    = NUM_CH'(1) << sel;
  // A beat counts when read data arrives or a valid write beat is taken.
  assign beat_ok   = own_wr ? (bus.bus_write_valid_o && bus.bus_wready_i) : bus.bus_rvalid_i;
  assign last_beat = (beat_cnt == own_size);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state                 <= IDLE;
      ptr                   <= '0;
      owner                 <= '0;
      own_wr                <= 1'b0;
      own_size              <= '0;
      beat_cnt              <= '0;
      tmo_cnt               <= '0;
      ch_ack_o              <= '0;
      ch_wnext_o            <= '0;
      ch_rvalid_o           <= '0;
      ch_rdata_o            <= '0;
      ch_done_o             <= '0;
      ch_err_o              <= '0;
      bus.bus_read_o        <= 1'b0;
      bus.bus_write_o       <= 1'b0;
      bus.bus_addr_o        <= '0;
      bus.bus_size_o        <= '1;
      bus.bus_wdata_o       <= '0;
      bus.bus_write_valid_o <= 1'b0;
    end else begin
      ch_ack_o    <= '0;
      ch_wnext_o  <= '0;
      ch_rvalid_o <= '0;
      ch_done_o   <= '0;
      ch_err_o    <= '0;
      case (state)
        IDLE: begin
          if (!stop_i && found) begin
            state           <= REQ;
            owner           <= sel;
            ptr             <= ptr_next;
            own_wr          <= ch_wr_i[sel];
            own_size        <= ch_size_i[sel];
            beat_cnt        <= '0;
            tmo_cnt         <= '0;
            ch_ack_o        <= sel_1h;
            bus.bus_addr_o  <= ch_addr_i[sel];
            bus.bus_size_o  <= ch_size_i[sel];
            bus.bus_read_o  <= !ch_wr_i[sel];
            bus.bus_write_o <= ch_wr_i[sel];
          end
        end
        REQ: begin
          // stop_i is checked first so it wins over a simultaneous grant.
          if (stop_i || tmo_cnt == TMO_LAST) begin
            state           <= ABORT;
            bus.bus_read_o  <= 1'b0;
            bus.bus_write_o <= 1'b0;
            ch_err_o        <= own_1h;
          end else if (bus.bus_grant_i) begin
            state           <= DATA;
            tmo_cnt         <= '0;
            bus.bus_read_o  <= 1'b0;
            bus.bus_write_o <= 1'b0;
            if (own_wr) begin
              bus.bus_write_valid_o <= 1'b1;
              bus.bus_wdata_o       <= ch_wdata_i[owner];
            end
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        DATA: begin
          if (stop_i) begin
            state                 <= ABORT;
            bus.bus_write_valid_o <= 1'b0;
            ch_err_o              <= own_1h;
          end else if (beat_ok) begin
            tmo_cnt  <= '0;
            beat_cnt <= beat_cnt + 1'b1;
            if (own_wr) begin
              ch_wnext_o            <= own_1h;
              bus.bus_write_valid_o <= 1'b0;
            end else begin
              ch_rvalid_o <= own_1h;
              ch_rdata_o  <= bus.bus_rdata_i;
            end
            if (last_beat) begin
              state     <= DONE;
              ch_done_o <= own_1h;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state                 <= ABORT;
            bus.bus_write_valid_o <= 1'b0;
            ch_err_o              <= own_1h;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
            // Gap cycle after a consumed beat: the channel has presented the next one.
            if (own_wr && !bus.bus_write_valid_o) begin
              bus.bus_write_valid_o <= 1'b1;
              bus.bus_wdata_o       <= ch_wdata_i[owner];
            end
          end
        end
        DONE: begin
          state          <= IDLE;
          bus.bus_size_o <= '1;
        end
        ABORT: begin
          state                 <= IDLE;
          bus.bus_size_o        <= '1;
          bus.bus_read_o        <= 1'b0;
          bus.bus_write_o       <= 1'b0;
          bus.bus_write_valid_o <= 1'b0;
        end
        default: begin
          state                 <= ABORT;
          bus.bus_read_o        <= 1'b0;
          bus.bus_write_o       <= 1'b0;
          bus.bus_write_valid_o <= 1'b0;
          ch_err_o              <= own_1h;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ip_codma_bus_master.sv
// Directed and randomized checks of ip_codma_bus_master against a transaction-level
// model: round-robin pointer, per-beat read/write data queues and pulse counts.
module tb_ip_codma_bus_master;
  localparam int NCH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic                  stop;
  logic [NCH-1:0]        req, wr, ack, wnext, rvalid, done, err;
  logic [NCH-1:0][31:0]  addr;
  logic [NCH-1:0][3:0]   size;
  logic [NCH-1:0][63:0]  wdata;
  logic [63:0]           rdata;
  logic [63:0]           wseed [NCH];
  int                    wbeat [NCH];
  int                    total = 0;
  int                    bad = 0;
  int                    tb_ptr = 0;

  ip_codma_bus_master_if #(.ADDR_W(32), .DATA_W(64), .SIZE_W(4)) bus ();

  ip_codma_bus_master #(
    .NUM_CH(NCH), .ADDR_W(32), .DATA_W(64), .SIZE_W(4), .TIMEOUT(16)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .stop_i(stop),
    .ch_req_i(req), .ch_wr_i(wr), .ch_addr_i(addr), .ch_size_i(size), .ch_wdata_i(wdata),
    .ch_ack_o(ack), .ch_wnext_o(wnext), .ch_rvalid_o(rvalid), .ch_rdata_o(rdata),
    .ch_done_o(done), .ch_err_o(err), .bus(bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] wpat(input int ch, input int k);
    return wseed[ch] ^ (64'(k) * 64'h9E37_79B9_7F4A_7C15);
  endfunction

  function automatic int rr_pick();
    for (int i = 0; i < NCH; i++) begin
      int c;
      c = (tb_ptr + i) % NCH;
      if (req[c]) return c;
    end
    return 0;
  endfunction

  task automatic setup(input int ch, input bit w, input logic [31:0] a, input logic [3:0] s);
    wr[ch]    = w;
    addr[ch]  = a;
    size[ch]  = s;
    wseed[ch] = {$urandom, $urandom};
    wbeat[ch] = 0;
    wdata[ch] = wpat(ch, 0);
    req[ch]   = 1'b1;
  endtask

  task automatic wait_ack(output bit ok);
    int n;
    n = 0;
    while (ack == '0 && n < 20) begin
      tick();
      n++;
    end
    ok = (ack != '0);
    chk("ack_seen", {63'd0, ok}, 64'd1);
  endtask

  // One full transaction: the bench plays the bus slave and scoreboards the beats.
  task automatic serve(input int exp_ch, input bit keep_req, input bit wready_always);
    bit          ok, is_wr;
    int          n, beats, sent, got, wn, dn, acc;
    logic [63:0] q[$];
    logic [63:0] e;
    wait_ack(ok);
    if (!ok) return;
    chk("ack_chan", 64'(ack), 64'(1 << exp_ch));
    tb_ptr = (exp_ch + 1) % NCH;
    if (!keep_req) req[exp_ch] = 1'b0;
    is_wr = wr[exp_ch];
    beats = int'(size[exp_ch]) + 1;
    chk("req_rd", 64'(bus.bus_read_o), 64'(!is_wr));
    chk("req_wr", 64'(bus.bus_write_o), 64'(is_wr));
    chk("req_addr", 64'(bus.bus_addr_o), 64'(addr[exp_ch]));
    chk("req_size", 64'(bus.bus_size_o), 64'(size[exp_ch]));
    repeat ($urandom_range(0, 5)) begin
      tick();
      chk("req_hold", 64'(bus.bus_read_o | bus.bus_write_o), 64'd1);
    end
    bus.bus_grant_i = 1'b1;
    tick();
    bus.bus_grant_i = 1'b0;
    chk("strobe_drop", 64'(bus.bus_read_o | bus.bus_write_o), 64'd0);
    sent = 0; got = 0; wn = 0; dn = 0; acc = 0;
    for (n = 0; n < 400 && dn == 0; n++) begin
      if (rvalid != '0) begin
        got++;
        chk("rvalid_chan", 64'(rvalid), 64'(1 << exp_ch));
        if (q.size() > 0) e = q.pop_front();
        else e = ~rdata;
        chk("rdata", rdata, e);
      end
      if (wnext != '0) begin
        wn++;
        chk("wnext_chan", 64'(wnext), 64'(1 << exp_ch));
        wbeat[exp_ch]++;
        wdata[exp_ch] = wpat(exp_ch, wbeat[exp_ch]);
      end
      if (err != '0) chk("err_unexpected", 64'(err), 64'd0);
      if (done != '0) begin
        dn++;
        chk("done_chan", 64'(done), 64'(1 << exp_ch));
      end
      bus.bus_rvalid_i = 1'b0;
      bus.bus_wready_i = 1'b0;
      if (dn == 0) begin
        if (!is_wr && sent < beats && $urandom_range(0, 3) != 0) begin
          bus.bus_rvalid_i = 1'b1;
          bus.bus_rdata_i  = {$urandom, $urandom};
          q.push_back(bus.bus_rdata_i);
          sent++;
        end
        if (is_wr && bus.bus_write_valid_o && (wready_always || $urandom_range(0, 3) != 0)) begin
          bus.bus_wready_i = 1'b1;
          chk("wdata", bus.bus_wdata_o, wpat(exp_ch, acc));
          acc++;
        end
      end
      if (dn == 0) tick();
    end
    bus.bus_rvalid_i = 1'b0;
    bus.bus_wready_i = 1'b0;
    chk("done_cnt", 64'(dn), 64'd1);
    chk("beat_cnt", 64'(is_wr ? wn : got), 64'(beats));
    chk("rq_empty", 64'(q.size()), 64'd0);
    tick();
    chk("idle_strobes", 64'({bus.bus_read_o, bus.bus_write_o, bus.bus_write_valid_o}), 64'd0);
    chk("idle_size", 64'(bus.bus_size_o), 64'hF);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    bit          ok;
    int          cnt;
    logic [NCH-1:0] seen;
    rst_n = 1'b1; stop = 1'b0; req = '0; wr = '0; addr = '0; size = '0; wdata = '0;
    bus.bus_grant_i = 1'b0; bus.bus_rvalid_i = 1'b0; bus.bus_rdata_i = '0; bus.bus_wready_i = 1'b0;
    for (int i = 0; i < NCH; i++) begin wseed[i] = '0; wbeat[i] = 0; end

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    chk("rst_strobes", 64'({bus.bus_read_o, bus.bus_write_o, bus.bus_write_valid_o}), 64'd0);
    chk("rst_size", 64'(bus.bus_size_o), 64'hF);
    chk("rst_addr", 64'(bus.bus_addr_o), 64'd0);
    chk("rst_wdata", bus.bus_wdata_o, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_pulses", 64'({ack, wnext, rvalid, done, err}), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // Channel 0 read of four beats at 0x1000
    setup(0, 1'b0, 32'h0000_1000, 4'd3);
    serve(rr_pick(), 1'b0, 1'b0);

    // Channel 1 write of two beats with the bus always ready
    setup(1, 1'b1, $urandom, 4'd1);
    serve(rr_pick(), 1'b0, 1'b1);

    // Randomized single-channel transactions
    for (int k = 0; k < 6; k++) begin
      setup($urandom_range(0, NCH - 1), 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 5)));
      serve(rr_pick(), 1'b0, 1'b0);
    end

    // Maximum size field: sixteen beats each way
    setup(0, 1'b0, $urandom, 4'hF);
    serve(rr_pick(), 1'b0, 1'b0);
    setup(1, 1'b1, $urandom, 4'hF);
    serve(rr_pick(), 1'b0, 1'b0);

    // stop_i held in IDLE blocks arbitration
    stop = 1'b1;
    setup(1, 1'b1, $urandom, 4'd2);
    seen = '0;
    repeat (6) begin tick(); seen |= ack; end
    chk("stop_idle_block", 64'(seen), 64'd0);
    stop = 1'b0;
    serve(rr_pick(), 1'b0, 1'b0);

    // No grant: abort after TIMEOUT cycles in REQ
    setup(1, 1'b0, $urandom, 4'd2);
    wait_ack(ok);
    tb_ptr = 0;
    req[1] = 1'b0;
    cnt = 0;
    while (err == '0 && cnt < 40) begin
      tick();
      cnt++;
      if (cnt == 15) chk("tmo_hold", 64'(bus.bus_read_o), 64'd1);
    end
    chk("tmo_cycles", 64'(cnt), 64'd16);
    chk("tmo_err", 64'(err), 64'b10);
    chk("tmo_strobe", 64'(bus.bus_read_o), 64'd0);
    tick();
    chk("tmo_err_pulse", 64'(err), 64'd0);
    chk("tmo_idle_size", 64'(bus.bus_size_o), 64'hF);

    // stop_i together with grant in REQ aborts without entering DATA
    setup(0, 1'b0, $urandom, 4'd1);
    wait_ack(ok);
    tb_ptr = 1;
    req[0] = 1'b0;
    stop = 1'b1;
    bus.bus_grant_i = 1'b1;
    tick();
    stop = 1'b0;
    bus.bus_grant_i = 1'b0;
    chk("stop_err", 64'(err), 64'b01);
    chk("stop_strobe", 64'(bus.bus_read_o), 64'd0);
    bus.bus_rvalid_i = 1'b1;
    bus.bus_rdata_i  = {$urandom, $urandom};
    tick();
    bus.bus_rvalid_i = 1'b0;
    seen = '0;
    repeat (3) begin tick(); seen |= rvalid | done; end
    chk("stop_no_data", 64'(seen), 64'd0);

    // Asynchronous reset in the middle of a write burst
    setup(1, 1'b1, $urandom, 4'd7);
    wait_ack(ok);
    req[1] = 1'b0;
    bus.bus_grant_i = 1'b1;
    tick();
    bus.bus_grant_i = 1'b0;
    chk("pre_rst_valid", 64'(bus.bus_write_valid_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.bus_write_valid_o), 64'd0);
    chk("arst_wdata", bus.bus_wdata_o, 64'd0);
    chk("arst_addr", 64'(bus.bus_addr_o), 64'd0);
    chk("arst_size", 64'(bus.bus_size_o), 64'hF);
    chk("arst_pulses", 64'({ack, wnext, rvalid, done, err}), 64'd0);
    seen = '0;
    repeat (2) begin @(posedge clk); #1 seen |= done | err; end
    #1 rst_n = 1'b1;
    repeat (3) begin tick(); seen |= done | err; end
    chk("arst_no_done_err", 64'(seen), 64'd0);
    tb_ptr = 0;

    // Both channels requesting continuously: acks alternate from channel 0
    setup(0, 1'b0, $urandom, 4'($urandom_range(0, 2)));
    setup(1, 1'b0, $urandom, 4'($urandom_range(0, 2)));
    for (int k = 0; k < 4; k++) begin
      serve(rr_pick(), 1'b1, 1'b0);
    end
    req = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ip_codma_bus_master.md
IP_CODMA_BUS_MASTER -- requirements
Module: ip_codma_bus_master

Interface
REQ-001 Parameter NUM_CH, default 2, number of requesting channels (range 1..8).
REQ-002 Parameter ADDR_W, default 32, bus address width.
REQ-003 Parameter DATA_W, default 64, bus data beat width.
REQ-004 Parameter SIZE_W, default 4, size field width; beats per transaction = size+1.
REQ-005 Parameter TIMEOUT, default 256, max cycles waiting for grant or a beat (range 2..65535).
REQ-006 clk_i  in  1  single clock, all logic on rising edge.
REQ-007 reset_n_i  in  1  asynchronous, active-low reset.
REQ-008 stop_i  in  1  abort current transaction.
REQ-009 ch_req_i  in  NUM_CH  per-channel request, level, held until ch_ack_o.
REQ-010 ch_wr_i  in  NUM_CH  per-channel direction, 1 = write, 0 = read.
REQ-011 ch_addr_i  in  NUM_CH x ADDR_W  per-channel start address.
REQ-012 ch_size_i  in  NUM_CH x SIZE_W  per-channel size field.
REQ-013 ch_wdata_i  in  NUM_CH x DATA_W  per-channel current write beat.
REQ-014 ch_ack_o  out  NUM_CH  one-cycle pulse: request accepted by arbiter.
REQ-015 ch_wnext_o  out  NUM_CH  one-cycle pulse: write beat consumed, present next.
REQ-016 ch_rvalid_o  out  NUM_CH  one-cycle pulse: ch_rdata_o holds a read beat.
REQ-017 ch_rdata_o  out  DATA_W  shared read data, registered.
REQ-018 ch_done_o  out  NUM_CH  one-cycle pulse: transaction completed.
REQ-019 ch_err_o  out  NUM_CH  one-cycle pulse: transaction aborted (timeout or stop_i).
REQ-020 bus_read_o, bus_write_o  out  1 each  bus request strobes.
REQ-021 bus_addr_o  out  ADDR_W; bus_size_o  out  SIZE_W; bus_wdata_o  out  DATA_W.
REQ-022 bus_write_valid_o  out  1  write beat valid.
REQ-023 bus_grant_i  in  1; bus_rvalid_i  in  1; bus_rdata_i  in  DATA_W; bus_wready_i  in  1.

Function
REQ-024 All outputs SHALL be registered; this block is the only driver of bus_* outputs.
REQ-025 FSM states SHALL be IDLE, REQ, DATA, DONE, ABORT; any other encoding SHALL go to ABORT next cycle.
REQ-026 IDLE: if any ch_req_i, select channel round-robin starting at ptr, pulse ch_ack_o, latch wr/addr/size, set ptr = selected+1 mod NUM_CH, go REQ.
REQ-027 REQ: assert bus_read_o or bus_write_o with latched addr/size; on bus_grant_i deassert strobe, go DATA.
REQ-028 DATA read: each bus_rvalid_i SHALL produce ch_rvalid_o with ch_rdata_o = bus_rdata_i one cycle later.
REQ-029 DATA write: bus_write_valid_o=1, bus_wdata_o = owner ch_wdata_i; beat accepted when bus_wready_i=1 while valid; then pulse ch_wnext_o and load next beat one cycle later (valid low for that cycle).
REQ-030 Beat counter SHALL count accepted beats; after beat size+1 go DONE; size all-ones gives 2^SIZE_W beats, no wrap.
REQ-031 DONE: pulse owner ch_done_o one cycle, return IDLE; earliest next ch_ack_o is the following cycle.
REQ-032 Timeout counter SHALL clear on entering REQ and on every accepted beat; reaching TIMEOUT-1 in REQ or DATA goes ABORT.
REQ-033 stop_i high in REQ or DATA SHALL go ABORT next cycle; stop_i in IDLE SHALL block new grants while high.
REQ-034 ABORT: deassert all bus strobes/valid, pulse owner ch_err_o one cycle, return IDLE.
REQ-035 Idle bus outputs: strobes 0, valid 0, bus_size_o all-ones, addr and wdata hold last value.
REQ-036 Simultaneous bus_grant_i and stop_i: stop_i SHALL win.

Reset
REQ-037 reset_n_i low SHALL immediately force: state IDLE, ptr 0, counters 0, all strobes/pulses 0, bus_addr_o 0, bus_wdata_o 0, ch_rdata_o 0, bus_size_o all-ones.
REQ-038 Reset mid-transaction SHALL drop it without ch_err_o or ch_done_o.

Verification
REQ-039 Ch0 read, addr 0x1000, size 3 -> bus_read_o until grant, 4 ch_rvalid_o[0] with matching data, ch_done_o[0] once.
REQ-040 Ch1 write, size 1, bus_wready_i always 1 -> 2 beats, ch_wnext_o[1] twice, ch_done_o[1].
REQ-041 Both channels requesting continuously, NUM_CH=2 -> ack order 0,1,0,1.
REQ-042 No grant, TIMEOUT=16 -> ch_err_o pulse 16 cycles after REQ entry, strobes low after.
REQ-043 stop_i asserted with bus_grant_i during REQ -> ABORT, ch_err_o, no DATA entry.
REQ-044 Reset pulse during DATA -> all outputs at reset values asynchronously, no done/err pulse.
